// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: writeback buffer in front of the 32x32 register file.
// Requests from the execution and load units are queued and then written to
// the single register-file write port at most one per cycle. A two-port
// forwarding lookup returns any value that is still waiting in the queue.
// Optional build macro: WBQ_COALESCE_EN. When it is defined, a new request
// overwrites the data of a queued entry with the same address instead of
// taking a new slot.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     drain_en,
    output logic                     wb_write,
    output logic [AW-1:0]            wb_addr,
    output logic [DW-1:0]            wb_data,
    input  logic [AW-1:0]            rd_addr1,
    output logic                     rd_hit1,
    output logic [DW-1:0]            rd_data1,
    input  logic [AW-1:0]            rd_addr2,
    output logic                     rd_hit2,
    output logic [DW-1:0]            rd_data2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];

    logic accept;
    logic store;
    logic alloc;

    // Handshake and write-port control use only registered state, so the
    // queue never passes a request straight through in the same cycle.
    always_comb begin
        in_ready = !rst && (count_q < CW'(DEPTH));
        accept   = in_valid && in_ready;
        store    = accept && (in_addr != '0);
        wb_write = drain_en && (count_q != '0) && !rst;
        wb_addr  = wb_write ? addr_q[head_q] : '0;
        wb_data  = wb_write ? data_q[head_q] : '0;
        count    = count_q;
    end

`ifdef WBQ_COALESCE_EN
    logic          co_hit;
    logic [PW-1:0] co_idx;

    // Find a queued entry with the same address; the head leaving this
    // cycle is excluded because its old value is already committed.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == in_addr) &&
                !((PW'(i) == head_q) && wb_write)) begin
                co_hit = 1'b1;
                co_idx = PW'(i);
            end
        end
        alloc = store && !co_hit;
    end
`else
    // Every nonzero-address request takes its own slot.
    always_comb begin
        alloc = store;
    end
`endif

    // Next-state for pointers, occupancy and entry storage.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (wb_write) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (alloc) begin
            addr_d[tail_q]  = in_addr;
            data_d[tail_q]  = in_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
`ifdef WBQ_COALESCE_EN
        if (store && co_hit) begin
            data_d[co_idx] = in_data;
        end
`endif
        count_d = count_q + CW'(alloc) - CW'(wb_write);
    end

    // Forwarding: walk from oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        rd_hit1  = 1'b0;
        rd_data1 = '0;
        rd_hit2  = 1'b0;
        rd_data2 = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (rd_addr1 != '0) && (addr_q[idx] == rd_addr1)) begin
                rd_hit1  = 1'b1;
                rd_data1 = data_q[idx];
            end
            if (valid_q[idx] && (rd_addr2 != '0) && (addr_q[idx] == rd_addr2)) begin
                rd_hit2  = 1'b1;
                rd_data2 = data_q[idx];
            end
        end
    end

    // State registers; reset empties the queue and drops pending entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Occupancy stays within range and register 0 is never written.
    assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (rst) wb_write |-> (wb_addr != '0));

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed test of the writeback queue with DEPTH=4.
// Expected values are hand-computed; coalescing expectations follow the
// WBQ_COALESCE_EN macro.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          wb_write;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rd_addr1;
    logic          rd_hit1;
    logic [DW-1:0] rd_data1;
    logic [AW-1:0] rd_addr2;
    logic          rd_hit2;
    logic [DW-1:0] rd_data2;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .drain_en (drain_en),
        .wb_write (wb_write),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rd_addr1 (rd_addr1),
        .rd_hit1  (rd_hit1),
        .rd_data1 (rd_data1),
        .rd_addr2 (rd_addr2),
        .rd_hit2  (rd_hit2),
        .rd_data2 (rd_data2),
        .count    (count)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic de);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        drain_en = de;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence; inputs change 1 unit after each rising edge and
    // outputs are checked 1 unit later, well clear of the next edge.
    initial begin
        rst      = 1'b1;
        rd_addr1 = '0;
        rd_addr2 = '0;
        applyStimulus(1'b1, 5'd3, 32'h1234, 1'b1);
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_wb_write", 32'(wb_write), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_rst_wb_write", 32'(wb_write), 32'd0);
        checkOutput("post_rst_hit1", 32'(rd_hit1), 32'd0);

        $display("[TB] test 1: single enqueue and lookup");
        rd_addr1 = 5'd3;
        rd_addr2 = 5'd4;
        applyStimulus(1'b1, 5'd3, 32'hAAAA, 1'b0);
        checkOutput("t1_req_not_visible", 32'(rd_hit1), 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t1_count", 32'(count), 32'd1);
        checkOutput("t1_hit1", 32'(rd_hit1), 32'd1);
        checkOutput("t1_data1", rd_data1, 32'hAAAA);
        checkOutput("t1_hit2", 32'(rd_hit2), 32'd0);
        checkOutput("t1_data2", rd_data2, 32'd0);
        checkOutput("t1_wb_write", 32'(wb_write), 32'd0);
        checkOutput("t1_wb_addr_idle", 32'(wb_addr), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t1_drain_write", 32'(wb_write), 32'd1);
        checkOutput("t1_drain_addr", 32'(wb_addr), 32'd3);
        checkOutput("t1_drain_data", wb_data, 32'hAAAA);
        checkOutput("t1_drain_still_hit", 32'(rd_hit1), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t1_empty_count", 32'(count), 32'd0);
        checkOutput("t1_empty_hit1", 32'(rd_hit1), 32'd0);

        $display("[TB] test 2: duplicate address");
        rd_addr1 = 5'd5;
        applyStimulus(1'b1, 5'd5, 32'h11, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd5, 32'h22, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t2_hit1", 32'(rd_hit1), 32'd1);
        checkOutput("t2_youngest", rd_data1, 32'h22);
`ifdef WBQ_COALESCE_EN
        checkOutput("t2_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t2_wb0_addr", 32'(wb_addr), 32'd5);
        checkOutput("t2_wb0_data", wb_data, 32'h22);
        tick();
`else
        checkOutput("t2_count", 32'(count), 32'd2);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t2_wb0_addr", 32'(wb_addr), 32'd5);
        checkOutput("t2_wb0_data", wb_data, 32'h11);
        tick();
        checkOutput("t2_wb1_write", 32'(wb_write), 32'd1);
        checkOutput("t2_wb1_data", wb_data, 32'h22);
        tick();
`endif
        checkOutput("t2_done_write", 32'(wb_write), 32'd0);
        checkOutput("t2_done_count", 32'(count), 32'd0);

        $display("[TB] test 3: full queue");
        for (int a = 1; a <= DEPTH; a++) begin
            applyStimulus(1'b1, AW'(a), 32'h100 + 32'(a), 1'b0);
            tick();
        end
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1);
        checkOutput("t3_full_ready", 32'(in_ready), 32'd0);
        checkOutput("t3_full_count", 32'(count), 32'd4);
        checkOutput("t3_first_wb_addr", 32'(wb_addr), 32'd1);
        checkOutput("t3_first_wb_data", wb_data, 32'h101);
        tick();
        checkOutput("t3_ready_again", 32'(in_ready), 32'd1);
        checkOutput("t3_count_after", 32'(count), 32'd3);
        checkOutput("t3_second_wb_addr", 32'(wb_addr), 32'd2);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t3_count_steady", 32'(count), 32'd3);
        checkOutput("t3_wb_addr_3", 32'(wb_addr), 32'd3);
        tick();
        checkOutput("t3_wb_addr_4", 32'(wb_addr), 32'd4);
        tick();
        checkOutput("t3_wb_addr_9", 32'(wb_addr), 32'd9);
        checkOutput("t3_wb_data_9", wb_data, 32'h99);
        tick();
        checkOutput("t3_empty_write", 32'(wb_write), 32'd0);
        checkOutput("t3_empty_count", 32'(count), 32'd0);

        $display("[TB] test 4: address zero");
        rd_addr1 = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b1);
        checkOutput("t4_ready", 32'(in_ready), 32'd1);
        checkOutput("t4_no_write_now", 32'(wb_write), 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t4_count", 32'(count), 32'd0);
        checkOutput("t4_no_write_after", 32'(wb_write), 32'd0);
        checkOutput("t4_hit1_zero", 32'(rd_hit1), 32'd0);

        $display("[TB] test 5: streaming with wrap");
        applyStimulus(1'b1, 5'd6, 32'h106, 1'b1);
        checkOutput("t5_no_bypass", 32'(wb_write), 32'd0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, AW'(6 + k), 32'h100 + 32'(6 + k), 1'b1);
            checkOutput("t5_count", 32'(count), 32'd1);
            checkOutput("t5_wb_addr", 32'(wb_addr), 32'(5 + k));
            checkOutput("t5_wb_data", wb_data, 32'h100 + 32'(5 + k));
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t5_last_addr", 32'(wb_addr), 32'd16);
        tick();
        checkOutput("t5_empty_count", 32'(count), 32'd0);

        $display("[TB] test 6: reset mid-drain");
        for (int a = 20; a <= 22; a++) begin
            applyStimulus(1'b1, AW'(a), 32'h200 + 32'(a), 1'b0);
            tick();
        end
        rd_addr1 = 5'd21;
        rd_addr2 = 5'd22;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t6_wb_addr_20", 32'(wb_addr), 32'd20);
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t6_rst_write", 32'(wb_write), 32'd0);
        checkOutput("t6_rst_addr", 32'(wb_addr), 32'd0);
        checkOutput("t6_rst_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t6_count", 32'(count), 32'd0);
        checkOutput("t6_write_after", 32'(wb_write), 32'd0);
        checkOutput("t6_hit1", 32'(rd_hit1), 32'd0);
        checkOutput("t6_hit2", 32'(rd_hit2), 32'd0);
        tick();
        checkOutput("t6_no_stale_write", 32'(wb_write), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writer-side companion to the 32x32 register file.
- Buffers writeback requests from execution and load units, then drains them one per cycle onto the register file's single write port (write, writeaddress, writedata).
- Gives operand-fetch readers a forwarding lookup, so a value still pending in the queue is returned in place of the stale register-file contents.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  writeback request valid
in_ready  out  1  queue can accept a request this cycle
in_addr  in  AW  destination register
in_data  in  DW  result value
drain_en  in  1  write port available this cycle
wb_write  out  1  to register file write
wb_addr  out  AW  to register file writeaddress
wb_data  out  DW  to register file writedata
rd_addr1  in  AW  lookup address, operand 1
rd_hit1  out  1  pending entry matches rd_addr1
rd_data1  out  DW  data of youngest matching entry
rd_addr2  in  AW  lookup address, operand 2
rd_hit2  out  1  pending entry matches rd_addr2
rd_data2  out  DW  data of youngest matching entry
count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset: clk and rst are synchronous, rst active-high. While rst is high and on the cycle after:
  - count=0; head and tail pointers=0; all valid bits cleared.
  - wb_write=0, rd_hit1=rd_hit2=0.
  - in_ready is forced 0 while rst=1.
  - Reset mid-operation discards all pending entries. No write is issued on the reset cycle.
- Storage: circular buffer of DEPTH entries {addr, data}. Pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- Enqueue handshake:
  - in_ready = !rst && (count<DEPTH).
  - A transfer occurs when in_valid && in_ready; the entry is written at tail on the next clk edge.
  - in_addr==0 is accepted (handshake completes) but not stored; count is unchanged.
  - in_ready is based on the registered count only. No same-cycle pass-through when full, even if a drain occurs that cycle.
- Drain (combinational from head):
  - wb_write = drain_en && count>0 && !rst.
  - wb_addr and wb_data = head entry. When wb_write=0, wb_addr and wb_data are 0.
  - Head advances on the clk edge where wb_write=1. The register file captures the same edge.
- Simultaneous enqueue and drain: count is unchanged, both pointers advance. Empty plus enqueue: the new entry is drainable on the following cycle, not the same cycle (0-cycle bypass is not allowed).
- Forwarding lookup (combinational):
  - rd_hitN=1 when any stored entry has addr==rd_addrN and rd_addrN!=0.
  - rd_dataN = data of the youngest match, i.e. nearest to tail. rd_dataN=0 on a miss.
  - The head entry being drained this cycle still counts as a hit; it reaches the register file only at the edge.
  - The in_* request of the current cycle is not visible to the lookup.
- Address 0 is never written to the register file and never hits.
- count is always 0..DEPTH. Underflow and overflow cannot occur by construction; a verification assertion checks this.

Optional Feature:
- Macro WBQ_COALESCE_EN.
- When defined: on an accepted enqueue whose in_addr matches a stored entry, that entry's data is overwritten in place and no new entry is allocated.
  - Exception: the matching entry is the head and is being drained this cycle. In that case a new entry is allocated normally.
  - In this mode at most one stored entry exists per address, apart from that head case.
  - in_ready remains !rst && (count<DEPTH); coalescing is not permitted when full.
- When undefined: every nonzero-address request allocates a new entry. Duplicate addresses drain in order.

Test Plan:
1. Reset, then enqueue {3,0xAAAA} with drain_en=0 -> count=1; lookup rd_addr1=3 gives rd_hit1=1, rd_data1=0xAAAA; rd_addr2=4 gives rd_hit2=0; wb_write=0.
2. Enqueue {5,0x11} then {5,0x22}, drain_en=0 -> rd_data1(5)=0x22. Macro off: count=2, then drain_en=1 produces wb writes 0x11 then 0x22. Macro on: count=1, single write 0x22.
3. Fill DEPTH=4 entries with addrs 1..4 -> in_ready=0. Hold in_valid with drain_en=1 -> wb_addr=1 on the first drain cycle; in_ready=1 on the next cycle.
4. Enqueue {0,0xFFFF} -> in_ready=1 and handshake completes; count stays 0; wb_write never asserts; rd_addr1=0 gives rd_hit1=0.
5. Enqueue and drain every cycle for 10 cycles with addrs 6,7,8,... -> count stays 1; wb_addr sequence lags input by 1 cycle; pointer wrap is exercised.
6. Queue holds 3 entries; assert rst for 1 cycle mid-drain -> wb_write=0 during reset; count=0 afterwards; all lookups miss; no stale writes issued.
